hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Feedback controller for the five-stage pipeline.
- Watches the instruction words and destination fields carried forward by the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Drives the enable and flush inputs of those registers and the PC.
- Produces ALU-operand forwarding selects, and runs a small FSM for multi-cycle data-memory waits with a timeout, plus saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 64: max cycles in MEMWAIT before entering ERR (1..65535).
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- id_inst  in  32  instruction in IF/ID.
- ex_inst  in  32  instruction in ID/EX.
- ex_memread  in  1  ID/EX instruction is a load.
- ex_regdst  in  5  ID/EX destination register.
- mem_regwrite  in  1  EX/MEM instruction writes a register.
- mem_regdst  in  5  EX/MEM destination register.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- wb_regwrite  in  1  MEM/WB instruction writes a register.
- wb_regdst  in  5  MEM/WB destination register.
- branch_taken  in  1  branch resolved taken in MEM.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble 32'hFF00_0000 on next edge.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- err  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- Register fields: rs = inst[25:21], rt = inst[20:16]. Bubble 32'hFF00_0000 never matches anything.
- Register 0 is never forwarded or stalled on.
- Forwarding, computed combinationally for ex_inst rs (fwd_a) and rt (fwd_b):
  - 10 if mem_regwrite and mem_regdst matches.
  - Else 01 if wb_regwrite and wb_regdst matches.
  - Else 00.
  - EX/MEM wins over MEM/WB.
- Load-use:
  - Condition: ex_memread and ex_regdst ≠ 0 and ex_regdst equals id rs or id rt.
  - Response: pc_en=0, ifid_en=0, idex_flush=1 for one cycle.
- Branch: branch_taken flushes IF/ID, ID/EX, EX/MEM; all enables 1 that cycle.
- FSM states RUN, MEMWAIT, ERR:
  - RUN → MEMWAIT when mem_req and !dmem_ready. Wait counter loads 1.
  - MEMWAIT: all four enables 0 and memwb_flush=1. Counter increments each cycle.
  - MEMWAIT → RUN on dmem_ready. That cycle the enables are 1 and normal hazard rules apply.
  - MEMWAIT → ERR when counter reaches TIMEOUT without dmem_ready.
  - ERR: all enables 0, all flushes 0, err=1. Exit only by reset.
- Priority: ERR > memory wait (including the RUN cycle with mem_req && !dmem_ready) > branch flush > load-use stall.
  - A branch_taken held in a frozen EX/MEM is acted on the cycle dmem_ready rises.
  - Load-use coinciding with a branch is dropped, because the flush removes both instructions.
- stall_cnt: +1 per cycle with pc_en=0, excluding ERR.
- flush_cnt: +1 per branch-flush cycle.
- Both counters saturate at all-ones.

## Timing
- Enables, flushes and fwd_* are combinational from inputs and state, valid before the next clk edge.
- err and the counters are registered.
- Reset (asynchronous, active-low):
  - State RUN; counters 0; err 0.
  - While rst_n=0: all enables 0, all flushes 1, fwd_a=fwd_b=00.
- Reset asserted mid-MEMWAIT or in ERR returns to RUN immediately. Counters clear.
- Load-use costs exactly one bubble.
- A memory access completing in its first cycle (dmem_ready with mem_req) costs zero stall cycles.
- A wait of N cycles costs N stall cycles.

## Structure
- Shared package `pipe_pkg`:
  - BUBBLE_INST = 32'hFF00_0000.
  - Field-slice constants for rs/rt.
  - FWD_RF/FWD_WB/FWD_MEM encodings.
  - FSM state enum.
- One natural sub-module, `fwd_sel`: combinational forwarding compare, instantiated twice (rs, rt).
- The FSM and counters live in hazard_ctrl.

## Test plan
- Forwarding: ex_inst rs=5, rt=6; mem_regdst=5 with mem_regwrite; wb_regdst=6 with wb_regwrite -> fwd_a=10, fwd_b=01. Repeat with regdst=0 -> both 00.
- Load-use: ex_memread=1, ex_regdst=8, id_inst rt=8 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt +1; next cycle all enables 1.
- Branch while load-use: branch_taken=1 with the load-use condition true -> ifid/idex/exmem_flush=1, pc_en=1, flush_cnt +1, stall_cnt unchanged.
- Memory wait of 3: mem_req=1, dmem_ready low 3 cycles then high -> 3 cycles of all enables 0 with memwb_flush=1, then RUN; stall_cnt=3.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> ERR after 4 cycles; err=1; enables and flushes 0; persists until rst_n low, then err=0 and state RUN.
- Counter saturation: CNT_W=4, 20 stall cycles -> stall_cnt=4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble word, register-field slices,
// forwarding-select encodings and the hazard controller state type.
package pipe_pkg;

  localparam logic [31:0] BUBBLE_INST = 32'hFF00_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_MEMWAIT = 2'b01,
    S_ERR     = 2'b10
  } state_e;

  function automatic logic [4:0] get_rs(input logic [31:0] inst);
    return inst[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] inst);
    return inst[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding compare for one EX source operand. The youngest producer
// (EX/MEM) wins over MEM/WB; register 0 and bubbles never forward.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic       src_valid,
  input  logic [4:0] src,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_regdst,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_regdst,
  output fwd_e       sel
);

  // Priority compare of the operand against the two in-flight producers
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that leaves sel unassigned would infer a latch.
    sel = FWD_RF;
    if (src_valid && (src != 5'd0)) begin
      if (mem_regwrite && (mem_regdst == src)) begin
        sel = FWD_MEM;
      end else if (wb_regwrite && (wb_regdst == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// branch flush, data-memory wait FSM with timeout, and saturating
// stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      ex_inst,
  input  logic             ex_memread,
  input  logic [4:0]       ex_regdst,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_regdst,
  input  logic             mem_req,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_regdst,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_e      state;
  logic [15:0] wait_cnt;
  fwd_e        sel_a;
  fwd_e        sel_b;
  logic        ex_valid;
  logic        id_valid;
  logic        load_use;
  logic        mem_wait;
  logic        branch_flush;

  assign ex_valid = (ex_inst != BUBBLE_INST);
  assign id_valid = (id_inst != BUBBLE_INST);

  fwd_sel u_fwd_rs (
    .src_valid    (ex_valid),
    .src          (get_rs(ex_inst)),
    .mem_regwrite (mem_regwrite),
    .mem_regdst   (mem_regdst),
    .wb_regwrite  (wb_regwrite),
    .wb_regdst    (wb_regdst),
    .sel          (sel_a)
  );

  fwd_sel u_fwd_rt (
    .src_valid    (ex_valid),
    .src          (get_rt(ex_inst)),
    .mem_regwrite (mem_regwrite),
    .mem_regdst   (mem_regdst),
    .wb_regwrite  (wb_regwrite),
    .wb_regdst    (wb_regdst),
    .sel          (sel_b)
  );

  assign fwd_a = rst_n ? sel_a : FWD_RF;
  assign fwd_b = rst_n ? sel_b : FWD_RF;

  assign load_use = ex_memread && (ex_regdst != 5'd0) && id_valid &&
                    ((ex_regdst == get_rs(id_inst)) || (ex_regdst == get_rt(id_inst)));

  // The first missed cycle in RUN already counts as a wait cycle
  assign mem_wait = ((state == S_RUN) && mem_req && !dmem_ready) ||
                    ((state == S_MEMWAIT) && !dmem_ready);

  assign branch_flush = rst_n && (state != S_ERR) && !mem_wait && branch_taken;

  // Stage enables and flushes by priority: reset, ERR, wait, branch, load-use
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!rst_n) begin
      {pc_en, ifid_en, idex_en, exmem_en}                  = 4'b0000;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush}   = 4'b1111;
    end else if (state == S_ERR) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
    end else if (mem_wait) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      memwb_flush = 1'b1;
    end else if (branch_flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Memory-wait FSM with timeout; err is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      wait_cnt <= 16'd0;
      err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so the order of statements does not change behaviour.
      case (state)
        S_RUN: begin
          if (mem_req && !dmem_ready) begin
            if (TIMEOUT == 1) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state    <= S_MEMWAIT;
              wait_cnt <= 16'd1;
            end
          end
        end
        S_MEMWAIT: begin
          if (dmem_ready) begin
            state <= S_RUN;
          end else if (wait_cnt >= WAIT_LAST) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state <= S_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != S_ERR) && !pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (branch_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4). Each cycle's
// expected outputs are queued when stimulus is applied and compared on the
// following falling edge.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  // Control vector order: pc, ifid, idex, exmem enables; ifid, idex, exmem, memwb flushes
  localparam logic [7:0] C_RESET = 8'h0F;
  localparam logic [7:0] C_IDLE  = 8'hF0;
  localparam logic [7:0] C_LUSE  = 8'h34;
  localparam logic [7:0] C_BR    = 8'hFE;
  localparam logic [7:0] C_WAIT  = 8'h01;
  localparam logic [7:0] C_ERR   = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   id_inst, ex_inst;
  logic          ex_memread;
  logic [4:0]    ex_regdst;
  logic          mem_regwrite;
  logic [4:0]    mem_regdst;
  logic          mem_req;
  logic          wb_regwrite;
  logic [4:0]    wb_regdst;
  logic          branch_taken;
  logic          dmem_ready;
  logic          pc_en, ifid_en, idex_en, exmem_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string         tag;
    logic [7:0]    ctrl;
    logic [3:0]    fwd;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_inst      (id_inst),
    .ex_inst      (ex_inst),
    .ex_memread   (ex_memread),
    .ex_regdst    (ex_regdst),
    .mem_regwrite (mem_regwrite),
    .mem_regdst   (mem_regdst),
    .mem_req      (mem_req),
    .wb_regwrite  (wb_regwrite),
    .wb_regdst    (wb_regdst),
    .branch_taken (branch_taken),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .err          (err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0000};
  endfunction

  // Queue the expectation for the current cycle, let the monitor compare it
  // on the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] ctrl, input logic [3:0] fwd,
                      input logic e, input logic [CW-1:0] st, input logic [CW-1:0] fl);
    exp_t x;
    x.tag = tag; x.ctrl = ctrl; x.fwd = fwd; x.err = e; x.stall = st; x.flush = fl;
    sb.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_inst = BUBBLE_INST; ex_inst = BUBBLE_INST;
    ex_memread = 1'b0; ex_regdst = 5'd0;
    mem_regwrite = 1'b0; mem_regdst = 5'd0; mem_req = 1'b0;
    wb_regwrite = 1'b0; wb_regdst = 5'd0;
    branch_taken = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic reset_dut(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    step(tag, C_RESET, 4'b0000, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b1;
  endtask

  // Monitor: pop one expectation per falling edge and compare
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".ctrl"}, 32'({pc_en, ifid_en, idex_en, exmem_en,
                                   ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(e.ctrl));
      check({e.tag, ".fwd"},   32'({fwd_a, fwd_b}), 32'(e.fwd));
      check({e.tag, ".err"},   32'(err),            32'(e.err));
      check({e.tag, ".stall"}, 32'(stall_cnt),      32'(e.stall));
      check({e.tag, ".flush"}, 32'(flush_cnt),      32'(e.flush));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and plain RUN
    reset_dut("reset");
    step("idle", C_IDLE, 4'b0000, 1'b0, 4'd0, 4'd0);

    // Forwarding
    ex_inst = mk(5'd5, 5'd6);
    mem_regwrite = 1'b1; mem_regdst = 5'd5;
    wb_regwrite  = 1'b1; wb_regdst  = 5'd6;
    step("fwd_mem_wb", C_IDLE, 4'b1001, 1'b0, 4'd0, 4'd0);
    wb_regdst = 5'd5;
    step("fwd_mem_wins", C_IDLE, 4'b1000, 1'b0, 4'd0, 4'd0);
    mem_regdst = 5'd6; wb_regdst = 5'd5;
    step("fwd_swap", C_IDLE, 4'b0110, 1'b0, 4'd0, 4'd0);
    ex_inst = mk(5'd0, 5'd0); mem_regdst = 5'd0; wb_regdst = 5'd0;
    step("fwd_r0", C_IDLE, 4'b0000, 1'b0, 4'd0, 4'd0);
    ex_inst = mk(5'd5, 5'd6); mem_regdst = 5'd5; wb_regdst = 5'd6;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    step("fwd_nowrite", C_IDLE, 4'b0000, 1'b0, 4'd0, 4'd0);
    ex_inst = BUBBLE_INST; wb_regwrite = 1'b1; wb_regdst = 5'd24;
    mem_regwrite = 1'b1; mem_regdst = 5'd0;
    step("fwd_bubble", C_IDLE, 4'b0000, 1'b0, 4'd0, 4'd0);
    idle_inputs();

    // Load-use stall, then release
    ex_memread = 1'b1; ex_regdst = 5'd8; id_inst = mk(5'd3, 5'd8);
    step("luse", C_LUSE, 4'b0000, 1'b0, 4'd0, 4'd0);
    idle_inputs();
    step("luse_after", C_IDLE, 4'b0000, 1'b0, 4'd1, 4'd0);
    ex_memread = 1'b1; ex_regdst = 5'd0; id_inst = mk(5'd0, 5'd0);
    step("luse_r0", C_IDLE, 4'b0000, 1'b0, 4'd1, 4'd0);
    ex_regdst = 5'd24; id_inst = BUBBLE_INST;
    step("luse_bubble", C_IDLE, 4'b0000, 1'b0, 4'd1, 4'd0);

    // Branch coinciding with load-use
    ex_regdst = 5'd8; id_inst = mk(5'd8, 5'd1); branch_taken = 1'b1;
    step("br_luse", C_BR, 4'b0000, 1'b0, 4'd1, 4'd0);
    idle_inputs();
    step("br_after", C_IDLE, 4'b0000, 1'b0, 4'd1, 4'd1);

    // Memory wait of three cycles
    reset_dut("reset_mw");
    mem_req = 1'b1; dmem_ready = 1'b0;
    step("mw1", C_WAIT, 4'b0000, 1'b0, 4'd0, 4'd0);
    step("mw2", C_WAIT, 4'b0000, 1'b0, 4'd1, 4'd0);
    step("mw3", C_WAIT, 4'b0000, 1'b0, 4'd2, 4'd0);
    dmem_ready = 1'b1;
    step("mw_done", C_IDLE, 4'b0000, 1'b0, 4'd3, 4'd0);
    step("mw_zero", C_IDLE, 4'b0000, 1'b0, 4'd3, 4'd0);
    idle_inputs();
    step("mw_idle", C_IDLE, 4'b0000, 1'b0, 4'd3, 4'd0);

    // Branch held in a frozen EX/MEM acts when the memory completes
    mem_req = 1'b1; branch_taken = 1'b1;
    step("mwbr_wait", C_WAIT, 4'b0000, 1'b0, 4'd3, 4'd0);
    dmem_ready = 1'b1;
    step("mwbr_go", C_BR, 4'b0000, 1'b0, 4'd4, 4'd0);
    idle_inputs();
    step("mwbr_idle", C_IDLE, 4'b0000, 1'b0, 4'd4, 4'd1);

    // Timeout into ERR, sticky until reset
    reset_dut("reset_to");
    mem_req = 1'b1;
    step("to1", C_WAIT, 4'b0000, 1'b0, 4'd0, 4'd0);
    step("to2", C_WAIT, 4'b0000, 1'b0, 4'd1, 4'd0);
    step("to3", C_WAIT, 4'b0000, 1'b0, 4'd2, 4'd0);
    step("to4", C_WAIT, 4'b0000, 1'b0, 4'd3, 4'd0);
    step("err1", C_ERR, 4'b0000, 1'b1, 4'd4, 4'd0);
    dmem_ready = 1'b1; branch_taken = 1'b1;
    step("err2", C_ERR, 4'b0000, 1'b1, 4'd4, 4'd0);
    reset_dut("rst_in_err");
    step("run_after_err", C_IDLE, 4'b0000, 1'b0, 4'd0, 4'd0);

    // Reset in the middle of a wait
    mem_req = 1'b1;
    step("mid1", C_WAIT, 4'b0000, 1'b0, 4'd0, 4'd0);
    step("mid2", C_WAIT, 4'b0000, 1'b0, 4'd1, 4'd0);
    reset_dut("rst_mid");
    step("run_after_mid", C_IDLE, 4'b0000, 1'b0, 4'd0, 4'd0);

    // Stall counter saturation
    ex_memread = 1'b1; ex_regdst = 5'd9; id_inst = mk(5'd9, 5'd2);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), C_LUSE, 4'b0000, 1'b0, (i > 15) ? 4'hF : 4'(i), 4'd0);
    end
    idle_inputs();
    step("sat_end", C_IDLE, 4'b0000, 1'b0, 4'hF, 4'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
